r_r16_gather_reader: RTL

- Read-side counterpart of the radix-16 bank write mux.
- On a start pulse, issues 16 single-word reads (one per memory bank) through one shared, bank-selected SRAM port.
- Captures the returned data after a fixed SRAM read latency and presents all 16 words together as one radix-16 butterfly input vector, in element order 0..15.
- Sits between the bank SRAM array and the R16 butterfly input registers.

---
 rtl/r_r16_gather_reader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/r_r16_gather_reader.sv
// Gathers one radix-16 butterfly input vector by reading the same word address
// from all 16 banks through a shared bank-selected SRAM port.
`ifndef MA_width
`define MA_width 10
`endif
`ifndef D_width
`define D_width 16
`endif

module r_r16_gather_reader #(
  parameter int MA_W   = `MA_width,
  parameter int D_W    = `D_width,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MA_W-1:0]   addr_in,
  input  logic [3:0]        rot_in,
  output logic              CEN_out,
  output logic              WEN_out,
  output logic [MA_W-1:0]   A_out,
  output logic [3:0]        sel_out,
  input  logic [D_W-1:0]    Q_in,
  output logic              busy,
  output logic              done,
  output logic [16*D_W-1:0] data_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        idx, idx_nxt;
  logic [3:0]        sel_nxt;
  logic [MA_W-1:0]   addr_nxt;
  logic              cen_nxt, busy_nxt, done_nxt;

  // Tags travelling alongside each outstanding read so returning data lands
  // in the right element without the SRAM having to identify it.
  logic              pipe_vld [RD_LAT];
  logic [3:0]        pipe_idx [RD_LAT];
  logic              cap_vld;
  logic [3:0]        cap_idx;

  assign cap_vld = pipe_vld[RD_LAT-1];
  assign cap_idx = pipe_idx[RD_LAT-1];
  assign WEN_out = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      sel_out <= '0;
      A_out   <= '0;
      CEN_out <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      sel_out <= sel_nxt;
      A_out   <= addr_nxt;
      CEN_out <= cen_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (idx == 4'd15) state_nxt = DRAIN;
      DRAIN:   if (cap_vld && cap_idx == 4'd15) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight
  // from a flop; sel_out itself serves as the latched rotation counter.
  always_comb begin
    idx_nxt  = idx;
    sel_nxt  = sel_out;
    addr_nxt = A_out;
    if (state == IDLE && start) begin
      idx_nxt  = '0;
      sel_nxt  = rot_in;
      addr_nxt = addr_in;
    end else if (state == ISSUE) begin
      idx_nxt = idx + 4'd1;
      sel_nxt = sel_out + 4'd1;
    end
    cen_nxt  = (state_nxt != ISSUE);
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_vld[k] <= 1'b0;
        pipe_idx[k] <= '0;
      end
    end else begin
      pipe_vld[0] <= (state == ISSUE);
      pipe_idx[0] <= idx;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_idx[k] <= pipe_idx[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (cap_vld) begin
      data_out[cap_idx*D_W +: D_W] <= Q_in;
    end
  end

endmodule
